jtag_dmi_ctrl: RTL

DMI access controller for the JTAG DTM, running in the TCK domain. It accepts the DMI scan value latched at UPDATE_DR and issues one valid/ready request to the debug module bus. It collects the response and keeps the sticky DMI status (ok/failed/busy) reported in the DMI op field and in dtmcs.dmistat. It also services the dtmcs dmireset and dmihardreset controls.

---
 rtl/jtag_dmi_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/jtag_dmi_ctrl.sv
// DMI access controller for the JTAG DTM (TCK domain): turns an UPDATE_DR scan
// into one debug-module bus request and keeps the sticky dmistat.
module jtag_dmi_ctrl #(
  parameter int unsigned ABITS     = 6,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [2:0]  IDLE_HINT = 3'd1
) (
  input  logic                      TCK,
  input  logic                      rst_n,
  input  logic                      dmi_update,
  input  logic                      dmi_capture,
  input  logic [ABITS+DATA_W+1:0]   dmi_wr,
  input  logic                      dmireset,
  input  logic                      dmihardreset,
  output logic [ABITS+DATA_W+1:0]   dmi_rd,
  output logic [1:0]                dmistat,
  output logic [2:0]                dtmcs_idle,
  output logic                      dm_req_valid,
  input  logic                      dm_req_ready,
  output logic [ABITS-1:0]          dm_req_addr,
  output logic [DATA_W-1:0]         dm_req_data,
  output logic [1:0]                dm_req_op,
  input  logic                      dm_resp_valid,
  input  logic [DATA_W-1:0]         dm_resp_data,
  input  logic                      dm_resp_err
);

  localparam int unsigned DMI_W = ABITS + DATA_W + 2;
  localparam int unsigned CNT_W = 16;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;
  localparam logic [1:0] ST_FAIL  = 2'd2;
  localparam logic [1:0] ST_BUSY  = 2'd3;

  logic [1:0]        state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d, cnt_inc;
  logic [1:0]        sticky, sticky_d;
  logic [ABITS-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] req_data_q, req_data_d;
  logic [1:0]        req_op_q, req_op_d;
  logic              valid_d;
  logic              timed_out, err_set, busy_set;

  logic [ABITS-1:0]  wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [1:0]        wr_op;

  assign wr_op   = dmi_wr[1:0];
  assign wr_data = dmi_wr[DATA_W+1:2];
  assign wr_addr = dmi_wr[DMI_W-1:DATA_W+2];

  // State and datapath registers
  always_ff @(posedge TCK or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      sticky       <= '0;
      addr_q       <= '0;
      rdata_q      <= '0;
      req_data_q   <= '0;
      req_op_q     <= '0;
      dm_req_valid <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      sticky       <= sticky_d;
      addr_q       <= addr_d;
      rdata_q      <= rdata_d;
      req_data_q   <= req_data_d;
      req_op_q     <= req_op_d;
      dm_req_valid <= valid_d;
    end
  end

  // Next-state, status and latch logic; hard reset overrides everything last
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    sticky_d   = sticky;
    addr_d     = addr_q;
    rdata_d    = rdata_q;
    req_data_d = req_data_q;
    req_op_d   = req_op_q;
    err_set    = 1'b0;
    cnt_inc    = cnt + CNT_W'(1);
    timed_out  = (cnt_inc >= CNT_W'(TIMEOUT));
    busy_set   = (state != S_IDLE) && (dmi_update || dmi_capture);

    case (state)
      S_IDLE: begin
        if (dmi_update && (sticky == 2'd0) && ((wr_op == OP_READ) || (wr_op == OP_WRITE))) begin
          addr_d     = wr_addr;
          req_data_d = wr_data;
          req_op_d   = wr_op;
          cnt_d      = '0;
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        cnt_d = cnt_inc;
        if (dm_req_valid && dm_req_ready) begin
          state_d = S_WAIT;
        end else if (timed_out) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          err_set = 1'b1;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_inc;
        if (dm_resp_valid) begin
          if (req_op_q == OP_READ) rdata_d = dm_resp_data;
          err_set = dm_resp_err;
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (timed_out) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          err_set = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (sticky == 2'd0) begin
      if (err_set)       sticky_d = ST_FAIL;
      else if (busy_set) sticky_d = ST_BUSY;
    end
    if (dmireset) sticky_d = 2'd0;

    if (dmihardreset) begin
      state_d    = S_IDLE;
      cnt_d      = '0;
      sticky_d   = 2'd0;
      addr_d     = addr_q;
      rdata_d    = rdata_q;
      req_data_d = req_data_q;
      req_op_d   = req_op_q;
    end

    valid_d = (state_d == S_REQ);
  end

  assign dmi_rd      = {addr_q, rdata_q, (state != S_IDLE) ? ST_BUSY : sticky};
  assign dmistat     = sticky;
  assign dtmcs_idle  = IDLE_HINT;
  assign dm_req_addr = addr_q;
  assign dm_req_data = req_data_q;
  assign dm_req_op   = req_op_q;

endmodule
